// File: rtl/elink_frame_assembler.sv
// E-link frame assembler: delimits decoded bytes into frames on K28.1/K28.6,
// stages payload in a frame FIFO and exposes a frame only once it commits.
// Malformed, oversize or overflowing frames are rolled back and counted.
//
// Handshakes: an input beat is taken whenever din_valid=1, with no stall in any
// state. An output byte moves when dout_valid & dout_ready are both high at a
// rising clk edge. dout_valid never depends on dout_ready.
module elink_frame_assembler #(
  parameter int          ADDR_W  = 6,
  parameter int          MAX_LEN = 16,
  parameter logic [7:0]  K_SOP   = 8'h3C,
  parameter logic [7:0]  K_EOP   = 8'hDC,
  parameter logic [7:0]  K_IDLE  = 8'hBC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_isk,
  input  logic       din_valid,
  output logic       fifo_full,
  output logic [7:0] dout,
  output logic       dout_last,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] frame_cnt,
  output logic [7:0] drop_cnt
);

  localparam int DEPTH_I = 2 ** ADDR_W;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  localparam logic [ADDR_W+1:0] DEPTH    = (ADDR_W+2)'(DEPTH_I);
  localparam logic [ADDR_W+1:0] FULL_THR = (ADDR_W+2)'(MAX_LEN + 1);
  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic [1:0]       state, state_n;
  logic [ADDR_W:0]  wr_ptr, wr_n;
  logic [ADDR_W:0]  commit_ptr, commit_n;
  logic [ADDR_W:0]  rd_ptr, rd_n;
  logic [7:0]       stg, stg_n;
  logic             stg_v, stg_v_n;
  logic [LEN_W-1:0] len, len_n;
  logic             we;
  logic [8:0]       wdata;
  logic             frame_inc, drop_inc;
  logic [ADDR_W:0]  used, used_n;
  logic [ADDR_W+1:0] free_n;
  logic             full;
  logic             rd_en;
  logic             is_sop, is_eop, is_idle;
  logic [8:0]       mem [DEPTH_I];
  logic [8:0]       head;

  assign used    = wr_ptr - rd_ptr;
  assign full    = used[ADDR_W];
  assign is_sop  = din_isk && (din == K_SOP);
  assign is_eop  = din_isk && (din == K_EOP);
  assign is_idle = din_isk && (din == K_IDLE);

  // Reader sees only committed entries; data masked to zero when empty.
  assign dout_valid = (rd_ptr != commit_ptr);
  assign rd_en      = dout_valid && dout_ready;
  assign head       = mem[rd_ptr[ADDR_W-1:0]];
  assign dout       = dout_valid ? head[7:0] : 8'h00;
  assign dout_last  = dout_valid ? head[8] : 1'b0;

  // Frame FSM: decide next pointers, staging and FIFO write for this beat.
  always_comb begin
    state_n   = state;
    wr_n      = wr_ptr;
    commit_n  = commit_ptr;
    stg_n     = stg;
    stg_v_n   = stg_v;
    len_n     = len;
    we        = 1'b0;
    wdata     = 9'h000;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    if (din_valid && !is_idle) begin
      case (state)
        IDLE: begin
          if (is_sop) begin
            state_n = PAYLOAD;
            len_n   = '0;
            stg_v_n = 1'b0;
          end
        end
        PAYLOAD: begin
          if (!din_isk) begin
            if ((len == LEN_MAX) || (stg_v && full)) begin
              wr_n     = commit_ptr;
              stg_v_n  = 1'b0;
              len_n    = '0;
              drop_inc = 1'b1;
              state_n  = DROP;
            end else begin
              if (stg_v) begin
                we    = 1'b1;
                wdata = {1'b0, stg};
                wr_n  = wr_ptr + PTR_ONE;
              end
              stg_n   = din;
              stg_v_n = 1'b1;
              len_n   = len + LEN_ONE;
            end
          end else if (is_eop) begin
            state_n = IDLE;
            stg_v_n = 1'b0;
            len_n   = '0;
            if (len != '0) begin
              if (full) begin
                // No room for the closing byte: discard the whole frame.
                wr_n     = commit_ptr;
                drop_inc = 1'b1;
              end else begin
                we        = 1'b1;
                wdata     = {1'b1, stg};
                wr_n      = wr_ptr + PTR_ONE;
                commit_n  = wr_ptr + PTR_ONE;
                frame_inc = 1'b1;
              end
            end
          end else if (is_sop) begin
            wr_n     = commit_ptr;
            stg_v_n  = 1'b0;
            len_n    = '0;
            drop_inc = 1'b1;
          end else begin
            wr_n     = commit_ptr;
            stg_v_n  = 1'b0;
            len_n    = '0;
            drop_inc = 1'b1;
            state_n  = DROP;
          end
        end
        DROP: begin
          if (is_eop) begin
            state_n = IDLE;
          end else if (is_sop) begin
            state_n = PAYLOAD;
            len_n   = '0;
            stg_v_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Post-edge pointer state feeds the registered backpressure flag.
  always_comb begin
    rd_n   = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;
    used_n = wr_n - rd_n;
    free_n = DEPTH - {1'b0, used_n};
  end

  // Control state, pointers, counters and backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      stg        <= 8'h00;
      stg_v      <= 1'b0;
      len        <= '0;
      frame_cnt  <= 8'h00;
      drop_cnt   <= 8'h00;
      fifo_full  <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_n;
      commit_ptr <= commit_n;
      rd_ptr     <= rd_n;
      stg        <= stg_n;
      stg_v      <= stg_v_n;
      len        <= len_n;
      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;
      if (drop_inc)  drop_cnt  <= drop_cnt + 8'd1;
      fifo_full  <= (free_n < FULL_THR);
    end
  end

  // Frame FIFO storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_elink_frame_assembler.sv
// Bench for elink_frame_assembler: directed frame scenarios with a
// scoreboard queue of expected {last, byte} entries popped by a read monitor.
module tb_elink_frame_assembler;

  localparam logic [7:0] K_SOP  = 8'h3C;
  localparam logic [7:0] K_EOP  = 8'hDC;
  localparam logic [7:0] K_IDLE = 8'hBC;
  localparam logic [7:0] K_BAD  = 8'hFC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_isk = 1'b0;
  logic       din_valid = 1'b0;
  logic       fifo_full;
  logic [7:0] dout;
  logic       dout_last;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic [7:0] frame_cnt;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  elink_frame_assembler dut (
    .clk(clk), .rst(rst), .din(din), .din_isk(din_isk), .din_valid(din_valid),
    .fifo_full(fifo_full), .dout(dout), .dout_last(dout_last),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // read monitor: sampled at negedge, transfer happens at the next posedge
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %0b/%02h, expected nothing", dout_last, dout);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({dout_last, dout} !== e) begin
          errors++;
          $display("FAIL read_data: got %0b/%02h, expected %0b/%02h", dout_last, dout, e[8], e[7:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic k, input logic [7:0] b);
    din = b; din_isk = k; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int bound, output bit timed_out);
    int n = 0;
    dout_ready = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); n++;
    end
    #1 dout_ready = 1'b0;
    timed_out = (exp_q.size() != 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (fifo_full !== 1'b0)   begin errors++; $display("FAIL rst_fifo_full: got %0b, expected 0", fifo_full); end
    checks++; if (dout_valid !== 1'b0)  begin errors++; $display("FAIL rst_dout_valid: got %0b, expected 0", dout_valid); end
    checks++; if (dout_last !== 1'b0)   begin errors++; $display("FAIL rst_dout_last: got %0b, expected 0", dout_last); end
    checks++; if (dout !== 8'h00)       begin errors++; $display("FAIL rst_dout: got %02h, expected 00", dout); end
    checks++; if (frame_cnt !== 8'h00)  begin errors++; $display("FAIL rst_frame_cnt: got %0d, expected 0", frame_cnt); end
    checks++; if (drop_cnt !== 8'h00)   begin errors++; $display("FAIL rst_drop_cnt: got %0d, expected 0", drop_cnt); end
  endtask

  task automatic test_good_frame();
    bit to;
    do_reset();
    send(1, K_SOP); send(0, 8'h11); send(0, 8'h22); send(0, 8'h33);
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL good_precommit_valid: got %0b, expected 0", dout_valid); end
    send(1, K_EOP);
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
    checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL good_latency_valid: got %0b, expected 1", dout_valid); end
    checks++; if (dout !== 8'h11)      begin errors++; $display("FAIL good_first_byte: got %02h, expected 11", dout); end
    checks++; if (frame_cnt !== 8'd1)  begin errors++; $display("FAIL good_frame_cnt: got %0d, expected 1", frame_cnt); end
    checks++; if (drop_cnt !== 8'd0)   begin errors++; $display("FAIL good_drop_cnt: got %0d, expected 0", drop_cnt); end
    drain(20, to);
    checks++; if (to) begin errors++; $display("FAIL good_drain: %0d left, expected 0", exp_q.size()); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL good_empty: got %0b, expected 0", dout_valid); end
  endtask

  task automatic test_idle_garbage();
    do_reset();
    repeat (5) send(1, K_IDLE);
    send(0, 8'h55);
    send(1, K_SOP);
    send(1, K_IDLE);
    send(1, K_EOP);
    checks++; if (dout_valid !== 1'b0)   begin errors++; $display("FAIL idle_valid: got %0b, expected 0", dout_valid); end
    checks++; if (dut.wr_ptr !== 7'd0)   begin errors++; $display("FAIL idle_wr_ptr: got %0d, expected 0", dut.wr_ptr); end
    checks++; if (frame_cnt !== 8'd0)    begin errors++; $display("FAIL idle_frame_cnt: got %0d, expected 0", frame_cnt); end
    checks++; if (drop_cnt !== 8'd0)     begin errors++; $display("FAIL idle_drop_cnt: got %0d, expected 0", drop_cnt); end
  endtask

  task automatic test_len_overflow();
    bit to;
    logic [7:0] b;
    do_reset();
    send(1, K_SOP);
    for (int i = 0; i < 17; i++) send(0, 8'($urandom_range(0, 255)));
    send(1, K_EOP);
    checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL ovf_drop_cnt: got %0d, expected 1", drop_cnt); end
    checks++; if (frame_cnt !== 8'd0)  begin errors++; $display("FAIL ovf_frame_cnt: got %0d, expected 0", frame_cnt); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid: got %0b, expected 0", dout_valid); end
    checks++; if (dut.wr_ptr !== 7'd0) begin errors++; $display("FAIL ovf_wr_ptr: got %0d, expected 0", dut.wr_ptr); end
    // exactly MAX_LEN bytes is still a legal frame
    send(1, K_SOP);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      send(0, b);
      exp_q.push_back({(i == 15), b});
    end
    send(1, K_EOP);
    send(1, K_SOP); send(0, 8'h5A); send(0, 8'h6B); send(1, K_EOP);
    exp_q.push_back(9'h05A); exp_q.push_back(9'h16B);
    checks++; if (frame_cnt !== 8'd2)  begin errors++; $display("FAIL ovf_after_frame_cnt: got %0d, expected 2", frame_cnt); end
    drain(40, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_re_sop();
    bit to;
    do_reset();
    send(1, K_SOP); send(0, 8'hA1); send(0, 8'hA2);
    send(1, K_SOP); send(0, 8'hB1); send(1, K_EOP);
    exp_q.push_back(9'h1B1);
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL resop_frame_cnt: got %0d, expected 1", frame_cnt); end
    checks++; if (drop_cnt !== 8'd1)  begin errors++; $display("FAIL resop_drop_cnt: got %0d, expected 1", drop_cnt); end
    drain(10, to);
    checks++; if (to) begin errors++; $display("FAIL resop_drain: %0d left, expected 0", exp_q.size()); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL resop_empty: got %0b, expected 0", dout_valid); end
  endtask

  task automatic test_bad_k();
    do_reset();
    send(1, K_SOP); send(0, 8'h01); send(1, K_BAD); send(0, 8'h02); send(1, K_EOP);
    send(1, K_SOP); send(1, K_EOP);
    checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL badk_drop_cnt: got %0d, expected 1", drop_cnt); end
    checks++; if (frame_cnt !== 8'd0)  begin errors++; $display("FAIL badk_frame_cnt: got %0d, expected 0", frame_cnt); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL badk_valid: got %0b, expected 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [7:0] b;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send(1, K_SOP);
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom_range(0, 255));
        send(0, b);
        exp_q.push_back({(i == 15), b});
      end
      send(1, K_EOP);
      if (f == 1) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL bp_full_at_32: got %0b, expected 0", fifo_full); end
      end
      if (f == 2) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full_at_48: got %0b, expected 1", fifo_full); end
      end
    end
    checks++; if (fifo_full !== 1'b1)  begin errors++; $display("FAIL bp_full_at_64: got %0b, expected 1", fifo_full); end
    checks++; if (frame_cnt !== 8'd4)  begin errors++; $display("FAIL bp_frame_cnt: got %0d, expected 4", frame_cnt); end
    send(1, K_SOP);
    for (int i = 0; i < 16; i++) send(0, 8'($urandom_range(0, 255)));
    send(1, K_EOP);
    checks++; if (drop_cnt !== 8'd1)   begin errors++; $display("FAIL bp_drop_cnt: got %0d, expected 1", drop_cnt); end
    checks++; if (frame_cnt !== 8'd4)  begin errors++; $display("FAIL bp_frame_cnt_after: got %0d, expected 4", frame_cnt); end
    checks++; if (exp_q.size() != 64)  begin errors++; $display("FAIL bp_queued: got %0d, expected 64", exp_q.size()); end
    drain(200, to);
    checks++; if (to) begin errors++; $display("FAIL bp_drain: %0d left, expected 0", exp_q.size()); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL bp_full_cleared: got %0b, expected 0", fifo_full); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b, expected 0", dout_valid); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send(1, K_SOP); send(0, 8'h77); send(1, K_EOP);
    send(1, K_SOP); send(0, 8'h01); send(0, 8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    send(1, K_EOP);
    checks++; if (dout_valid !== 1'b0)  begin errors++; $display("FAIL midrst_valid: got %0b, expected 0", dout_valid); end
    checks++; if (frame_cnt !== 8'd0)   begin errors++; $display("FAIL midrst_frame_cnt: got %0d, expected 0", frame_cnt); end
    checks++; if (drop_cnt !== 8'd0)    begin errors++; $display("FAIL midrst_drop_cnt: got %0d, expected 0", drop_cnt); end
    checks++; if (dut.state !== 2'd0)   begin errors++; $display("FAIL midrst_state: got %0d, expected 0", dut.state); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_idle_garbage();
    test_len_overflow();
    test_re_sop();
    test_bad_k();
    test_backpressure();
    test_reset_mid_frame();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
